// File: rtl/tx_gearbox_if.sv
// Bus bundle between the 64b/66b encoder side and the 32-bit TX gearbox.
interface tx_gearbox_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned HDR_WIDTH  = 2
);
    logic [DATA_WIDTH-1:0] i_tx_data;
    logic                  i_tx_data_valid;
    logic [HDR_WIDTH-1:0]  i_tx_sync_hdr;
    logic                  i_tx_sync_hdr_valid;
    logic                  o_tx_ready;
    logic [DATA_WIDTH-1:0] o_tx_data;
    logic [5:0]            o_tx_seq;
    logic                  o_underflow;
    logic                  o_hdr_err;

    modport master (
        output i_tx_data, i_tx_data_valid, i_tx_sync_hdr, i_tx_sync_hdr_valid,
        input  o_tx_ready, o_tx_data, o_tx_seq, o_underflow, o_hdr_err
    );

    modport slave (
        input  i_tx_data, i_tx_data_valid, i_tx_sync_hdr, i_tx_sync_hdr_valid,
        output o_tx_ready, o_tx_data, o_tx_seq, o_underflow, o_hdr_err
    );
endinterface

// File: rtl/tx_gearbox.sv
// 66b-to-32b TX gearbox: two 32-bit half-blocks plus a 2-bit header per block,
// packed LSB first into 32-bit words over a 33-cycle sequence with one pause.
module tx_gearbox #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned HDR_WIDTH  = 2
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    tx_gearbox_if.slave   bus
);
    localparam int unsigned SEQ_W   = 6;
    localparam int unsigned CNT_W   = 7;
    localparam int unsigned BUF_W   = 2 * DATA_WIDTH;
    localparam logic [SEQ_W-1:0] SEQ_PAUSE = SEQ_W'(32);

    logic [SEQ_W-1:0]      seq_q, seq_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0]      res_cnt_q, res_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  underflow_q, underflow_d;
    logic                  hdr_err_q, hdr_err_d;

    logic                  ready_c;
    logic                  hdr_phase_c;
    logic [DATA_WIDTH-1:0] in_data_c;
    logic [HDR_WIDTH-1:0]  in_hdr_c;
    logic [BUF_W-1:0]      app_c;
    logic [CNT_W-1:0]      app_len_c;
    logic [BUF_W-1:0]      buf_c;

    // Next-state: append this cycle's bits above the residual, emit the oldest 32.
    always_comb begin
        ready_c     = i_reset_n && (seq_q != SEQ_PAUSE);
        hdr_phase_c = !seq_q[0] && (seq_q != SEQ_PAUSE);
        in_data_c   = bus.i_tx_data_valid ? bus.i_tx_data     : '0;
        in_hdr_c    = bus.i_tx_data_valid ? bus.i_tx_sync_hdr : '0;
        app_c       = '0;
        app_len_c   = '0;
        if (ready_c) begin
            if (hdr_phase_c) begin
                app_c     = BUF_W'({in_data_c, in_hdr_c});
                app_len_c = CNT_W'(DATA_WIDTH + HDR_WIDTH);
            end else begin
                app_c     = BUF_W'(in_data_c);
                app_len_c = CNT_W'(DATA_WIDTH);
            end
        end
        buf_c       = (app_c << res_cnt_q) | BUF_W'(res_q);
        data_d      = buf_c[DATA_WIDTH-1:0];
        res_d       = buf_c[BUF_W-1:DATA_WIDTH];
        res_cnt_d   = res_cnt_q + app_len_c - CNT_W'(DATA_WIDTH);
        underflow_d = underflow_q || (ready_c && !bus.i_tx_data_valid);
        // Header-valid must line up with the even phases; it never steers insertion.
        hdr_err_d   = bus.i_tx_sync_hdr_valid ? !hdr_phase_c
                                              : (hdr_phase_c && bus.i_tx_data_valid);
        seq_d       = (seq_q == SEQ_PAUSE) ? '0 : seq_q + SEQ_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            seq_q       <= '0;
            res_q       <= '0;
            res_cnt_q   <= '0;
            data_q      <= '0;
            underflow_q <= 1'b0;
            hdr_err_q   <= 1'b0;
        end else begin
            seq_q       <= seq_d;
            res_q       <= res_d;
            res_cnt_q   <= res_cnt_d;
            data_q      <= data_d;
            underflow_q <= underflow_d;
            hdr_err_q   <= hdr_err_d;
        end
    end

    assign bus.o_tx_ready  = ready_c;
    assign bus.o_tx_data   = data_q;
    assign bus.o_tx_seq    = seq_q;
    assign bus.o_underflow = underflow_q;
    assign bus.o_hdr_err   = hdr_err_q;
endmodule

// File: tb/tb_tx_gearbox.sv
// Bench for tx_gearbox: a bit-queue serializer model checked every cycle,
// plus hand-computed literals for the first words, residual, and error flags.
module tb_tx_gearbox;
    logic i_clk = 1'b0;
    logic i_reset_n;
    always #5 i_clk = ~i_clk;

    tx_gearbox_if #(.DATA_WIDTH(32), .HDR_WIDTH(2)) bus ();

    tx_gearbox #(.DATA_WIDTH(32), .HDR_WIDTH(2)) u_dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model state: sequence position, pending serial bits, expected registered outputs.
    int          m_seq    = 0;
    bit          q[$];
    logic [31:0] exp_data = '0;
    logic        exp_uf   = 1'b0;
    logic        exp_herr = 1'b0;

    logic win_en = 1'b0;
    int   cyc    = 0;
    int   low_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (model seq %0d, t=%0t)",
                     name, act, exp, m_seq, $time);
        end
    endtask

    function automatic logic good_hv(input int s);
        return (s % 2 == 0) && (s < 32);
    endfunction

    task automatic model_reset();
        m_seq    = 0;
        q.delete();
        exp_data = '0;
        exp_uf   = 1'b0;
        exp_herr = 1'b0;
    endtask

    // Advance the model by one clock using the inputs that were present at the edge.
    task automatic model_advance();
        logic        hdr_slot;
        logic [31:0] d;
        logic [1:0]  h;
        if (!i_reset_n) begin
            model_reset();
            return;
        end
        hdr_slot = good_hv(m_seq);
        exp_herr = bus.i_tx_sync_hdr_valid ? !hdr_slot : (hdr_slot && bus.i_tx_data_valid);
        if (m_seq != 32) begin
            d = bus.i_tx_data_valid ? bus.i_tx_data     : 32'h0;
            h = bus.i_tx_data_valid ? bus.i_tx_sync_hdr : 2'b00;
            if (!bus.i_tx_data_valid) exp_uf = 1'b1;
            if (hdr_slot) for (int i = 0; i < 2; i++) q.push_back(h[i]);
            for (int i = 0; i < 32; i++) q.push_back(d[i]);
        end
        for (int i = 0; i < 32; i++) exp_data[i] = (q.size() > 0) ? q.pop_front() : 1'b0;
        m_seq = (m_seq == 32) ? 0 : m_seq + 1;
    endtask

    task automatic step(input logic [31:0] d, input logic dv, input logic [1:0] h, input logic hv);
        bus.i_tx_data           = d;
        bus.i_tx_data_valid     = dv;
        bus.i_tx_sync_hdr       = h;
        bus.i_tx_sync_hdr_valid = hv;
        @(posedge i_clk);
        #1;
        model_advance();
    endtask

    task automatic step_good();
        step($urandom, 1'b1, 2'($urandom), good_hv(m_seq));
    endtask

    // Every-cycle comparison against the model.
    always @(negedge i_clk) begin
        cyc++;
        check("ready",     32'(bus.o_tx_ready),  32'(i_reset_n && (m_seq != 32)));
        check("seq",       32'(bus.o_tx_seq),    32'(m_seq));
        check("data",      bus.o_tx_data,        exp_data);
        check("underflow", 32'(bus.o_underflow), 32'(exp_uf));
        check("hdr_err",   32'(bus.o_hdr_err),   32'(exp_herr));
        if (win_en && !bus.o_tx_ready) low_cyc.push_back(cyc);
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  h;

        i_reset_n = 1'b1;
        bus.i_tx_data = '0; bus.i_tx_data_valid = 1'b0;
        bus.i_tx_sync_hdr = '0; bus.i_tx_sync_hdr_valid = 1'b0;
        #1 i_reset_n = 1'b0;
        repeat (3) step(32'h0, 1'b0, 2'b00, 1'b0);
        i_reset_n = 1'b1;

        // Fixed pattern: 16 blocks of hdr 01, A5/5A halves, then junk at the pause.
        for (int k = 0; k < 33; k++) begin
            if (m_seq == 32) step($urandom, 1'b1, 2'($urandom), 1'b0);
            else step((m_seq % 2 == 0) ? 32'hA5A5A5A5 : 32'h5A5A5A5A, 1'b1, 2'b01, good_hv(m_seq));
            if (k == 0) begin
                check("first_word", bus.o_tx_data, 32'h96969695);
                check("first_hdr",  32'(bus.o_tx_data[1:0]), 32'h1);
            end
            if (k == 1)  check("second_word", bus.o_tx_data, 32'h6969696A);
            if (k == 32) check("pause_residual", bus.o_tx_data, 32'h5A5A5A5A);
        end

        // Three random periods; ready must drop exactly once per period.
        win_en = 1'b1;
        repeat (99) step_good();
        win_en = 1'b0;
        check("ready_low_count", 32'(low_cyc.size()), 32'd3);
        if (low_cyc.size() == 3) begin
            check("ready_gap1", 32'(low_cyc[1] - low_cyc[0]), 32'd33);
            check("ready_gap2", 32'(low_cyc[2] - low_cyc[1]), 32'd33);
        end

        // Header-valid at a data phase.
        while (m_seq != 3) step_good();
        step($urandom, 1'b1, 2'($urandom), 1'b1);
        check("hdr_err_pulse", 32'(bus.o_hdr_err), 32'h1);
        step_good();
        check("hdr_err_clear", 32'(bus.o_hdr_err), 32'h0);

        // Missing data at seq 5: zero slot, sticky underflow.
        while (m_seq != 5) step_good();
        check("underflow_before", 32'(bus.o_underflow), 32'h0);
        step($urandom, 1'b0, 2'b00, 1'b0);
        check("underflow_set", 32'(bus.o_underflow), 32'h1);
        check("underflow_zero_slot", bus.o_tx_data >> 6, 32'h0);
        repeat (40) step_good();
        check("underflow_sticky", 32'(bus.o_underflow), 32'h1);

        // Reset in the middle of a period.
        while (m_seq != 17) step_good();
        i_reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_data",  bus.o_tx_data, 32'h0);
        check("rst_ready", 32'(bus.o_tx_ready), 32'h0);
        check("rst_seq",   32'(bus.o_tx_seq), 32'h0);
        check("rst_uf",    32'(bus.o_underflow), 32'h0);
        repeat (2) step($urandom, 1'b1, 2'($urandom), 1'b1);
        i_reset_n = 1'b1;
        d = $urandom;
        h = 2'($urandom);
        step(d, 1'b1, h, 1'b1);
        check("rst_first_word", bus.o_tx_data, (d << 2) | 32'(h));
        check("rst_seq_next",   32'(bus.o_tx_seq), 32'h1);

        // Fully random traffic including drops and misplaced header-valid.
        repeat (150) begin
            logic hv;
            hv = good_hv(m_seq);
            if ($urandom_range(0, 7) == 0) hv = !hv;
            step($urandom, ($urandom_range(0, 9) != 0), 2'($urandom), hv);
        end

        @(negedge i_clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
